conv_window_ctrl: RTL and testbench

- Upstream feeder and sequencer for one conv_node.
- Accepts a stream of input columns (KERNEL_HEIGHT words each) over a valid/ready handshake and keeps a sliding KERNEL_HEIGHT x KERNEL_WIDTH window.
- For every complete window, drives the node's start / input_index / add_bias sequence and the weight-memory address, then pulses done_o when the node's data_o is valid.
- Sits between the input sample buffer and the conv_node array; all nodes in a layer share its window and control outputs.

---
 rtl/conv_pkg.sv | 18 +
 rtl/conv_window_shift.sv | 41 ++++
 rtl/conv_window_ctrl.sv | 150 +++++++++++++++
 tb/tb_conv_window_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types for the convolution window controller: FSM state encoding and
// the index-width helper used to size the input index / weight address.
package conv_pkg;

    typedef enum logic [2:0] {
        FILL,
        START,
        MAC,
        BIAS,
        DONE
    } state_t;

    // Index must reach N (the bias slot), hence N+1 distinct values.
    function automatic int idx_width(input int kernel_height, input int kernel_width);
        return $clog2(kernel_height * kernel_width + 1);
    endfunction

endpackage

// File: rtl/conv_window_shift.sv
// Sliding window of KERNEL_WIDTH input columns; column k is replaced by column k+1
// on load, the newest column enters at k = KERNEL_WIDTH-1.
module conv_window_shift #(
    parameter int WORD_SIZE     = 16,
    parameter int KERNEL_HEIGHT = 3,
    parameter int KERNEL_WIDTH  = 2
) (
    input  logic                                                clk_i,
    input  logic                                                clear_i,
    input  logic                                                load_i,
    input  logic [KERNEL_HEIGHT-1:0][WORD_SIZE-1:0]             data_i,
    output logic [KERNEL_HEIGHT-1:0][KERNEL_WIDTH-1:0][WORD_SIZE-1:0] window_o
);

    logic [KERNEL_HEIGHT-1:0][KERNEL_WIDTH-1:0][WORD_SIZE-1:0] window_reg;
    logic [KERNEL_HEIGHT-1:0][KERNEL_WIDTH-1:0][WORD_SIZE-1:0] window_next;

    genvar gi, gk;
    generate
        for (gi = 0; gi < KERNEL_HEIGHT; gi++) begin : g_row
            for (gk = 0; gk < KERNEL_WIDTH; gk++) begin : g_col
                if (gk == KERNEL_WIDTH - 1) begin : g_newest
                    assign window_next[gi][gk] = data_i[gi];
                end else begin : g_shift
                    assign window_next[gi][gk] = window_reg[gi][gk+1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            window_reg <= '0;
        end else if (load_i) begin
            window_reg <= window_next;
        end
    end

    assign window_o = window_reg;

endmodule

// File: rtl/conv_window_ctrl.sv
// Window feeder and start/index/bias sequencer for one conv_node layer.
// Optional window counter enabled by defining CONV_WINDOW_CTRL_PERF_EN.
module conv_window_ctrl
    import conv_pkg::*;
#(
    parameter int WORD_SIZE     = 16,
    parameter int KERNEL_HEIGHT = 3,
    parameter int KERNEL_WIDTH  = 2,
    localparam int N            = KERNEL_HEIGHT * KERNEL_WIDTH,
    localparam int IDX_W        = idx_width(KERNEL_HEIGHT, KERNEL_WIDTH)
) (
    input  logic                                                      clk_i,
    input  logic                                                      reset_n_i,
    input  logic                                                      valid_i,
    output logic                                                      ready_o,
    input  logic [KERNEL_HEIGHT-1:0][WORD_SIZE-1:0]                   data_i,
    input  logic                                                      last_i,
    output logic [KERNEL_HEIGHT-1:0][KERNEL_WIDTH-1:0][WORD_SIZE-1:0] window_o,
    output logic                                                      start_o,
    output logic [IDX_W-1:0]                                          input_index_o,
    output logic                                                      add_bias_o,
    output logic [IDX_W-1:0]                                          weight_addr_o,
    output logic                                                      done_o,
    output logic                                                      last_o,
    output logic [31:0]                                               window_count_o
);

    localparam int FC_W = $clog2(KERNEL_WIDTH + 1);

    state_t           state_reg;
    logic [FC_W-1:0]  fill_cnt_reg;
    logic [FC_W-1:0]  fill_cnt_next;
    logic             last_flag_reg;
    logic             start_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             add_bias_reg;
    logic             done_reg;
    logic             last_out_reg;
    logic             accept;

    // Gating with reset keeps ready low while reset is held and high right after.
    assign ready_o = (state_reg == FILL) && reset_n_i;
    assign accept  = valid_i && ready_o;

    always_comb begin
        fill_cnt_next = fill_cnt_reg;
        if (fill_cnt_reg != FC_W'(KERNEL_WIDTH)) begin
            fill_cnt_next = fill_cnt_reg + FC_W'(1);
        end
    end

    conv_window_shift #(
        .WORD_SIZE    (WORD_SIZE),
        .KERNEL_HEIGHT(KERNEL_HEIGHT),
        .KERNEL_WIDTH (KERNEL_WIDTH)
    ) u_shift (
        .clk_i   (clk_i),
        .clear_i (!reset_n_i),
        .load_i  (accept),
        .data_i  (data_i),
        .window_o(window_o)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_reg     <= FILL;
            fill_cnt_reg  <= '0;
            last_flag_reg <= 1'b0;
            start_reg     <= 1'b0;
            idx_reg       <= '0;
            add_bias_reg  <= 1'b0;
            done_reg      <= 1'b0;
            last_out_reg  <= 1'b0;
        end else begin
            start_reg    <= 1'b0;
            add_bias_reg <= 1'b0;
            done_reg     <= 1'b0;
            last_out_reg <= 1'b0;
            case (state_reg)
                FILL: begin
                    if (accept) begin
                        fill_cnt_reg  <= fill_cnt_next;
                        last_flag_reg <= last_i;
                        if (fill_cnt_next == FC_W'(KERNEL_WIDTH)) begin
                            state_reg <= START;
                            start_reg <= 1'b1;
                            idx_reg   <= '0;
                        end
                    end
                end
                START: begin
                    state_reg <= MAC;
                    idx_reg   <= '0;
                end
                MAC: begin
                    if (idx_reg == IDX_W'(N - 1)) begin
                        state_reg    <= BIAS;
                        add_bias_reg <= 1'b1;
                        idx_reg      <= IDX_W'(N);
                    end else begin
                        idx_reg <= idx_reg + IDX_W'(1);
                    end
                end
                BIAS: begin
                    state_reg    <= DONE;
                    done_reg     <= 1'b1;
                    last_out_reg <= last_flag_reg;
                    idx_reg      <= '0;
                end
                DONE: begin
                    state_reg <= FILL;
                    // After a final column the next sequence starts from an empty window.
                    if (last_flag_reg) begin
                        fill_cnt_reg  <= '0;
                        last_flag_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= FILL;
                end
            endcase
        end
    end

    assign start_o       = start_reg;
    assign input_index_o = idx_reg;
    assign weight_addr_o = idx_reg;
    assign add_bias_o    = add_bias_reg;
    assign done_o        = done_reg;
    assign last_o        = last_out_reg;

`ifdef CONV_WINDOW_CTRL_PERF_EN
    logic [31:0] window_count_reg;

    // Counted on the BIAS->DONE edge so the value already includes the window
    // whose done_o is being shown.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            window_count_reg <= '0;
        end else if (state_reg == BIAS) begin
            window_count_reg <= window_count_reg + 32'd1;
        end
    end

    assign window_count_o = window_count_reg;
`else
    assign window_count_o = '0;
`endif

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Self-checking bench for conv_window_ctrl (KERNEL_HEIGHT=3, KERNEL_WIDTH=2).
// Define CONV_WINDOW_CTRL_PERF_EN for both bench and RTL to exercise the counter.
module tb_conv_window_ctrl;

    localparam int WS    = 16;
    localparam int KH    = 3;
    localparam int KW    = 2;
    localparam int N     = KH * KW;
    localparam int IDX_W = 3;

    typedef logic [KH-1:0][WS-1:0]         col_t;
    typedef logic [KH-1:0][KW-1:0][WS-1:0] win_t;

    logic             clk_i     = 1'b0;
    logic             reset_n_i = 1'b0;
    logic             valid_i   = 1'b0;
    logic             last_i    = 1'b0;
    col_t             data_i    = '0;
    logic             ready_o;
    win_t             window_o;
    logic             start_o;
    logic [IDX_W-1:0] input_index_o;
    logic             add_bias_o;
    logic [IDX_W-1:0] weight_addr_o;
    logic             done_o;
    logic             last_o;
    logic [31:0]      window_count_o;

    conv_window_ctrl #(
        .WORD_SIZE    (WS),
        .KERNEL_HEIGHT(KH),
        .KERNEL_WIDTH (KW)
    ) dut (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .data_i        (data_i),
        .last_i        (last_i),
        .window_o      (window_o),
        .start_o       (start_o),
        .input_index_o (input_index_o),
        .add_bias_o    (add_bias_o),
        .weight_addr_o (weight_addr_o),
        .done_o        (done_o),
        .last_o        (last_o),
        .window_count_o(window_count_o)
    );

    always #5 clk_i = ~clk_i;

    int   checks  = 0;
    int   errors  = 0;
    // Reference model: every column accepted since reset, the spec's fill rule,
    // the pending last flag and the number of completed windows.
    col_t hist[$];
    int   fill     = 0;
    bit   seq_last = 1'b0;
    int   windows  = 0;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic col_t mkcol(input int base);
        col_t c;
        for (int r = 0; r < KH; r++) c[r] = WS'(base + r);
        return c;
    endfunction

    function automatic win_t model_win();
        win_t w = '0;
        for (int k = 0; k < KW; k++) begin
            int h;
            h = hist.size() - KW + k;
            if (h >= 0) begin
                for (int r = 0; r < KH; r++) w[r][k] = hist[h][r];
            end
        end
        return w;
    endfunction

    function automatic logic [31:0] exp_count();
`ifdef CONV_WINDOW_CTRL_PERF_EN
        return 32'(windows);
`else
        return 32'd0;
`endif
    endfunction

    // Offer one column, wait for acceptance, then follow the window sequence.
    // abort_at > 0 returns right after checking that cycle of the sequence.
    task automatic push(input col_t col, input bit last, input bit hold, input col_t nxt,
                        input int abort_at);
        int waited = 0;
        valid_i = 1'b1;
        data_i  = col;
        last_i  = last;
        while (!ready_o && waited < 20) begin
            step();
            waited++;
        end
        check("ready_wait", ready_o, 1'b1);
        step();
        if (hold) begin
            data_i = nxt;
            last_i = 1'b0;
        end else begin
            valid_i = 1'b0;
            last_i  = 1'b0;
        end
        hist.push_back(col);
        fill     = (fill + 1 > KW) ? KW : fill + 1;
        seq_last = last;
        if (fill < KW) begin
            $display("column %0h accepted, filling (%0d/%0d)", col, fill, KW);
            check("fill_no_start", start_o, 1'b0);
            check("fill_ready", ready_o, 1'b1);
            check("fill_window", window_o, model_win());
            return;
        end
        for (int c = 1; c <= N + 3; c++) begin
            int exp_idx;
            if (c > 1) step();
            exp_idx = (c <= 1) ? 0 : (c <= N + 1) ? c - 2 : N;
            check("busy_ready", ready_o, 1'b0);
            check("start", start_o, c == 1);
            check("add_bias", add_bias_o, c == N + 2);
            check("done", done_o, c == N + 3);
            check("window_stable", window_o, model_win());
            if (c <= N + 2) begin
                check("input_index", input_index_o, exp_idx);
                check("weight_addr", weight_addr_o, exp_idx);
            end
            if (c == abort_at) return;
            if (c == N + 3) begin
                windows++;
                check("last_o", last_o, seq_last);
                check("window_count", window_count_o, exp_count());
                $display("window %0d done last=%0d window=%0h", windows, last_o, window_o);
                if (seq_last) begin
                    fill     = 0;
                    seq_last = 1'b0;
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, ready_o, 1'b0);
        check({tag, "_start"}, start_o, 1'b0);
        check({tag, "_idx"}, input_index_o, 0);
        check({tag, "_addr"}, weight_addr_o, 0);
        check({tag, "_bias"}, add_bias_o, 1'b0);
        check({tag, "_done"}, done_o, 1'b0);
        check({tag, "_last"}, last_o, 1'b0);
        check({tag, "_window"}, window_o, 0);
        check({tag, "_count"}, window_count_o, 0);
    endtask

    initial begin
        // Reset
        step();
        step();
        check_reset_outputs("reset");
        reset_n_i = 1'b1;
        #1;
        check("reset_release_ready", ready_o, 1'b1);

        // Two columns back to back, then a stride-1 column
        push(mkcol(1), 1'b0, 1'b0, '0, 0);
        push(mkcol(4), 1'b0, 1'b0, '0, 0);
        push(mkcol(7), 1'b0, 1'b0, '0, 0);

        // valid_i held high across busy periods with an incrementing pattern
        for (int i = 0; i < 4; i++) begin
            push(mkcol(16 + 3 * i), 1'b0, 1'b1, mkcol(16 + 3 * (i + 1)), 0);
        end
        valid_i = 1'b0;

        // last_i on a completing column, then a fresh 2-column fill
        push(mkcol(40), 1'b1, 1'b0, '0, 0);
        push(mkcol(43), 1'b0, 1'b0, '0, 0);
        push(mkcol(46), 1'b1, 1'b0, '0, 0);

        // Reset during MAC idx=3 (cycle 5 of the sequence)
        push(mkcol(50), 1'b0, 1'b0, '0, 0);
        push(mkcol(53), 1'b0, 1'b0, '0, 5);
        reset_n_i = 1'b0;
        step();
        check_reset_outputs("abort");
        hist.delete();
        fill     = 0;
        seq_last = 1'b0;
        windows  = 0;
        reset_n_i = 1'b1;
        #1;
        check("abort_release_ready", ready_o, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("abort_no_done", done_o, 1'b0);
        end
        push(mkcol(60), 1'b0, 1'b0, '0, 0);
        push(mkcol(63), 1'b0, 1'b0, '0, 0);

        // Randomised columns, last flags and idle gaps
        for (int i = 0; i < 14; i++) begin
            int gap;
            col_t c;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) step();
            for (int r = 0; r < KH; r++) c[r] = WS'($urandom);
            push(c, $urandom_range(0, 3) == 0, 1'b0, '0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
